// File: rtl/muldiv_unit_if.sv
// Issue/readback bundle between the EX stage and the multiply/divide unit.
// The unit sits on the slave side; the pipeline drives the master side.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hilo_sel;
  logic             flush;
  logic [WIDTH-1:0] rdata;
  logic             busy;

  modport master (
    output start, op, a, b, hilo_sel, flush,
    input  rdata, busy
  );

  modport slave (
    input  start, op, a, b, hilo_sel, flush,
    output rdata, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO; result precomputed at issue.
// Define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (ops 7-10).
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam int W2      = 2 * WIDTH;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [W2-1:0]    pend;
  logic             pend_we;

  logic op_mult;
  logic op_multu;
  logic op_div;
  logic op_divu;
  logic op_mthi;
  logic op_mtlo;
  logic op_acc;

  assign op_mult  = bus.op == 4'd1;
  assign op_multu = bus.op == 4'd2;
  assign op_div   = bus.op == 4'd3;
  assign op_divu  = bus.op == 4'd4;
  assign op_mthi  = bus.op == 4'd5;
  assign op_mtlo  = bus.op == 4'd6;

  logic [W2-1:0] sa;
  logic [W2-1:0] sb;
  logic [W2-1:0] prod_s;
  logic [W2-1:0] prod_u;

  assign sa     = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
  assign sb     = {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
  assign prod_s = sa * sb;
  assign prod_u = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};

`ifdef MULDIV_MADD_EN
  logic          op_madd;
  logic          op_maddu;
  logic          op_msub;
  logic          op_msubu;
  logic [W2-1:0] hilo;

  assign op_madd  = bus.op == 4'd7;
  assign op_maddu = bus.op == 4'd8;
  assign op_msub  = bus.op == 4'd9;
  assign op_msubu = bus.op == 4'd10;
  assign op_acc   = op_madd | op_maddu | op_msub | op_msubu;
  assign hilo     = {hi, lo};
`else
  assign op_acc = 1'b0;
`endif

  // MIN_INT / -1 overflows the quotient; pin it to the wrapped result
  logic             min_ovf;
  logic             b_zero;
  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] q_u;
  logic [WIDTH-1:0] r_u;

  assign min_ovf = (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.b);
  assign b_zero  = bus.b == '0;
  assign q_s = min_ovf ? bus.a :
               WIDTH'($signed(bus.a) / $signed(bus.b));
  assign r_s = min_ovf ? '0 :
               WIDTH'($signed(bus.a) % $signed(bus.b));
  assign q_u = bus.a / bus.b;
  assign r_u = bus.a % bus.b;

  logic          multi;
  logic          accept;
  logic [W2-1:0] res;
  logic          res_we;
  logic [CW-1:0] lat;

  assign multi  = op_mult | op_multu | op_div | op_divu | op_acc;
  assign accept = (state == IDLE) & bus.start & ~bus.flush &
                  (multi | op_mthi | op_mtlo);

  always_comb begin
    res    = '0;
    res_we = 1'b1;
    lat    = MUL_CNT;
    unique case (1'b1)
      op_mult:  res = prod_s;
      op_multu: res = prod_u;
      op_div: begin
        res    = {r_s, q_s};
        res_we = ~b_zero;
        lat    = DIV_CNT;
      end
      op_divu: begin
        res    = {r_u, q_u};
        res_we = ~b_zero;
        lat    = DIV_CNT;
      end
`ifdef MULDIV_MADD_EN
      op_madd:  res = hilo + prod_s;
      op_maddu: res = hilo + prod_u;
      op_msub:  res = hilo - prod_s;
      op_msubu: res = hilo - prod_u;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend    <= '0;
      pend_we <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        if (op_mthi) begin
          hi <= bus.a;
        end else if (op_mtlo) begin
          lo <= bus.a;
        end else begin
          pend    <= res;
          pend_we <= res_we;
          cnt     <= lat;
          state   <= RUN;
        end
      end
    end else begin
      // flush outranks a completion landing on the same edge
      if (bus.flush) begin
        cnt   <= '0;
        state <= IDLE;
      end else if (cnt == ONE) begin
        if (pend_we) begin
          {hi, lo} <= pend;
        end
        cnt   <= '0;
        state <= IDLE;
      end else begin
        cnt <= cnt - ONE;
      end
    end
  end

  assign bus.rdata = bus.hilo_sel ? hi : lo;
  assign bus.busy  = state == RUN;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised self-checking bench for muldiv_unit against an arithmetic
// model of HI/LO; build with MULDIV_MADD_EN to cover the accumulate ops.
module tb_muldiv_unit;
  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = 10;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [W-1:0] hi_m;
  logic [W-1:0] lo_m;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(
    .WIDTH(W),
    .MUL_LAT(ML),
    .DIV_LAT(DL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_lat(input logic [3:0] op);
    case (op)
      4'd1, 4'd2: return ML;
      4'd3, 4'd4: return DL;
`ifdef MULDIV_MADD_EN
      4'd7, 4'd8, 4'd9, 4'd10: return ML;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic void model(input logic [3:0] op,
                                input logic [W-1:0] a,
                                input logic [W-1:0] b);
    longint sa;
    longint sb;
    logic [63:0] acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    acc = {hi_m, lo_m};
    case (op)
      4'd1: acc = 64'(sa * sb);
      4'd2: acc = {32'd0, a} * {32'd0, b};
      4'd3: if (b != 0) acc = {32'(sa % sb), 32'(sa / sb)};
      4'd4: if (b != 0) acc = {a % b, a / b};
      4'd5: acc[63:32] = a;
      4'd6: acc[31:0] = a;
`ifdef MULDIV_MADD_EN
      4'd7:  acc = acc + 64'(sa * sb);
      4'd8:  acc = acc + {32'd0, a} * {32'd0, b};
      4'd9:  acc = acc - 64'(sa * sb);
      4'd10: acc = acc - {32'd0, a} * {32'd0, b};
`endif
      default: ;
    endcase
    {hi_m, lo_m} = acc;
  endfunction

  // Called at a negedge; returns at the first negedge with busy low.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, output int n);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 4'd0;
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic read_hilo(output logic [W-1:0] h, output logic [W-1:0] l);
    bus.hilo_sel = 1'b1;
    #1 h = bus.rdata;
    bus.hilo_sel = 1'b0;
    #1 l = bus.rdata;
  endtask

  task automatic test_reset();
    logic [W-1:0] h, l;
    int n;
    read_hilo(h, l);
    checks++;
    if (h !== '0 || l !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals hi=%h lo=%h busy=%b want 0/0/0", h, l, bus.busy);
    end
    @(negedge clk);
    issue(4'd5, 32'hA5A5_0001, 32'd0, n);
    issue(4'd6, 32'h5A5A_0002, 32'd0, n);
    bus.start = 1'b1;
    bus.op    = 4'd1;
    bus.a     = 32'd1234;
    bus.b     = 32'd5678;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy busy=%b want 0", bus.busy);
    end
    read_hilo(h, l);
    checks++;
    if (h !== '0 || l !== '0) begin
      errors++;
      $display("FAIL reset_hilo hi=%h lo=%h want 0/0", h, l);
    end
    reset = 1'b1;
    hi_m = '0;
    lo_m = '0;
    repeat (8) @(negedge clk);
    read_hilo(h, l);
    checks++;
    if (h !== '0 || l !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release hi=%h lo=%h busy=%b want 0/0/0", h, l, bus.busy);
    end
  endtask

  task automatic test_mult();
    logic [W-1:0] h, l, a, b;
    logic [3:0] op;
    int n;
    issue(4'd1, 32'hFFFF_FFFE, 32'd3, n);
    read_hilo(h, l);
    checks++;
    if (n !== ML || h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL mult_neg n=%0d hi=%h lo=%h want %0d/ffffffff/fffffffa", n, h, l, ML);
    end
    issue(4'd2, 32'hFFFF_FFFE, 32'd3, n);
    read_hilo(h, l);
    checks++;
    if (n !== ML || h !== 32'h0000_0002 || l !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL multu n=%0d hi=%h lo=%h want %0d/00000002/fffffffa", n, h, l, ML);
    end
    for (int i = 0; i < 8; i++) begin
      op = ($urandom_range(0, 1) == 0) ? 4'd1 : 4'd2;
      a  = $urandom;
      b  = $urandom;
      model(op, a, b);
      issue(op, a, b, n);
      read_hilo(h, l);
      checks++;
      if (n !== ML || h !== hi_m || l !== lo_m) begin
        errors++;
        $display("FAIL mult_rand op=%0d a=%h b=%h n=%0d hi=%h lo=%h want %0d/%h/%h",
                 op, a, b, n, h, l, ML, hi_m, lo_m);
      end
    end
  endtask

  task automatic test_div();
    logic [W-1:0] h, l, a, b;
    logic [3:0] op;
    int n;
    issue(4'd3, -32'sd7, 32'd2, n);
    read_hilo(h, l);
    checks++;
    if (n !== DL || l !== 32'hFFFF_FFFD || h !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL div_neg n=%0d hi=%h lo=%h want %0d/ffffffff/fffffffd", n, h, l, DL);
    end
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
    read_hilo(h, l);
    hi_m = h;
    lo_m = l;
    checks++;
    if (n !== DL || l !== 32'h8000_0000 || h !== 32'h0) begin
      errors++;
      $display("FAIL div_minint n=%0d hi=%h lo=%h want %0d/00000000/80000000", n, h, l, DL);
    end
    hi_m = 32'h0;
    lo_m = 32'h8000_0000;
    for (int i = 0; i < 10; i++) begin
      op = ($urandom_range(0, 1) == 0) ? 4'd3 : 4'd4;
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom_range(1, 300);
      if ($urandom_range(0, 1) == 0) b = -b;
      model(op, a, b);
      issue(op, a, b, n);
      read_hilo(h, l);
      checks++;
      if (n !== DL || h !== hi_m || l !== lo_m) begin
        errors++;
        $display("FAIL div_rand op=%0d a=%h b=%h n=%0d hi=%h lo=%h want %0d/%h/%h",
                 op, a, b, n, h, l, DL, hi_m, lo_m);
      end
    end
  endtask

  task automatic test_divzero();
    logic [W-1:0] h, l, h0;
    int n;
    issue(4'd6, 32'h0000_1234, 32'd0, n);
    model(4'd6, 32'h0000_1234, 32'd0);
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL mtlo_busy n=%0d want 0", n);
    end
    read_hilo(h0, l);
    checks++;
    if (l !== 32'h0000_1234) begin
      errors++;
      $display("FAIL mtlo_val lo=%h want 00001234", l);
    end
    issue(4'd4, 32'd99, 32'd0, n);
    read_hilo(h, l);
    checks++;
    if (n !== DL || l !== 32'h0000_1234 || h !== hi_m) begin
      errors++;
      $display("FAIL divu_zero n=%0d hi=%h lo=%h want %0d/%h/00001234", n, h, l, DL, hi_m);
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] h, l;
    int n;
    issue(4'd5, 32'h1111_1111, 32'd0, n);
    issue(4'd6, 32'h2222_2222, 32'd0, n);
    model(4'd5, 32'h1111_1111, 32'd0);
    model(4'd6, 32'h2222_2222, 32'd0);
    bus.start = 1'b1;
    bus.op    = 4'd1;
    bus.a     = 32'd7;
    bus.b     = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    read_hilo(h, l);
    checks++;
    if (bus.busy !== 1'b0 || h !== hi_m || l !== lo_m) begin
      errors++;
      $display("FAIL flush_mid busy=%b hi=%h lo=%h want 0/%h/%h", bus.busy, h, l, hi_m, lo_m);
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (ML - 1) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    read_hilo(h, l);
    checks++;
    if (bus.busy !== 1'b0 || h !== hi_m || l !== lo_m) begin
      errors++;
      $display("FAIL flush_last busy=%b hi=%h lo=%h want 0/%h/%h", bus.busy, h, l, hi_m, lo_m);
    end
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = 4'd5;
    bus.a     = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    read_hilo(h, l);
    checks++;
    if (bus.busy !== 1'b0 || h !== hi_m || l !== lo_m) begin
      errors++;
      $display("FAIL flush_idle busy=%b hi=%h lo=%h want 0/%h/%h", bus.busy, h, l, hi_m, lo_m);
    end
  endtask

  task automatic test_madd();
    logic [W-1:0] h, l, a, b;
    logic [3:0] op;
    int n;
    issue(4'd5, 32'h0, 32'd0, n);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0, n);
    model(4'd5, 32'h0, 32'd0);
    model(4'd6, 32'hFFFF_FFFF, 32'd0);
    issue(4'd8, 32'd1, 32'd1, n);
    model(4'd8, 32'd1, 32'd1);
    read_hilo(h, l);
    checks++;
`ifdef MULDIV_MADD_EN
    if (n !== ML || h !== 32'd1 || l !== 32'd0) begin
      errors++;
      $display("FAIL maddu n=%0d hi=%h lo=%h want %0d/00000001/00000000", n, h, l, ML);
    end
`else
    if (n !== 0 || h !== 32'd0 || l !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL maddu_off n=%0d hi=%h lo=%h want 0/00000000/ffffffff", n, h, l);
    end
`endif
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(7, 10));
      a  = $urandom;
      b  = $urandom;
      model(op, a, b);
      issue(op, a, b, n);
      read_hilo(h, l);
      checks++;
      if (n !== exp_lat(op) || h !== hi_m || l !== lo_m) begin
        errors++;
        $display("FAIL madd_rand op=%0d n=%0d hi=%h lo=%h want %0d/%h/%h",
                 op, n, h, l, exp_lat(op), hi_m, lo_m);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] h, l, a, b;
    logic [3:0] op;
    int n;
    for (int i = 0; i < 16; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      model(op, a, b);
      issue(op, a, b, n);
      read_hilo(h, l);
      checks++;
      if (n !== exp_lat(op) || h !== hi_m || l !== lo_m) begin
        errors++;
        $display("FAIL b2b op=%0d a=%h b=%h n=%0d hi=%h lo=%h want %0d/%h/%h",
                 op, a, b, n, h, l, exp_lat(op), hi_m, lo_m);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks       = 0;
    errors       = 0;
    hi_m         = '0;
    lo_m         = '0;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.op       = 4'd0;
    bus.a        = '0;
    bus.b        = '0;
    bus.hilo_sel = 1'b0;
    bus.flush    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_divzero();
    test_flush();
    test_madd();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
